// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: skid-stage state encoding and the
// ID/EXE field layout used by the wrapper that packs ctrl/data.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int EXE_CMD_W = 4;
  localparam int IMM24_W   = 24;
  localparam int SHOP_W    = 12;
  localparam int REG_W     = 4;
  localparam int PC_W      = 32;

  // ID/EXE control layout (10 bits total)
  localparam int CTRL_WB_EN_BIT   = 0;
  localparam int CTRL_MEM_R_BIT   = 1;
  localparam int CTRL_MEM_W_BIT   = 2;
  localparam int CTRL_EXE_CMD_LSB = 3;
  localparam int CTRL_B_BIT       = CTRL_EXE_CMD_LSB + EXE_CMD_W;
  localparam int CTRL_S_BIT       = CTRL_B_BIT + 1;
  localparam int CTRL_C_BIT       = CTRL_S_BIT + 1;
  localparam int ID_EXE_CTRL_W    = CTRL_C_BIT + 1;

  // ID/EXE payload layout (low fields first, remaining bits carry operand values)
  localparam int DATA_DEST_LSB  = 0;
  localparam int DATA_SHOP_LSB  = DATA_DEST_LSB + REG_W;
  localparam int DATA_IMM24_LSB = DATA_SHOP_LSB + SHOP_W;
  localparam int DATA_PC_LSB    = DATA_IMM24_LSB + IMM24_W;
  localparam int DATA_VAL_LSB   = DATA_PC_LSB + PC_W;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid + control + payload. Clearing always drops
// valid and zeroes control; payload is zeroed only when clear_data is also set.
module pipe_slot #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              clear_data,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld  <= 1'b0;
      ctrl <= '0;
      data <= '0;
    end else if (clear) begin
      vld  <= 1'b0;
      ctrl <= '0;
      if (clear_data) data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      ctrl <= ctrl_d;
      data <= data_d;
    end
  end

endmodule

// File: rtl/id_exe_skid_stage.sv
// Valid/ready pipeline register with a two-entry skid buffer; in_ready is a
// flop so no combinational path runs from out_ready back upstream.
module id_exe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 10,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic [1:0]        state, state_nxt;
  logic              accept, emit;
  logic              main_load, main_from_skid, main_clr;
  logic              skid_load, skid_clr;
  logic              skid_vld;
  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] skid_data, main_data_d;
  logic              clr_data;

  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign occupancy = state;
  assign clr_data  = flush & CLEAR_DATA;

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && emit) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_nxt = ST_FULL;
        end else if (emit) begin
          main_clr  = 1'b1;
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_nxt      = ST_BUSY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any transfer in the same cycle; the incoming beat is dropped
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .load       (main_load),
    .clear      (main_clr),
    .clear_data (clr_data),
    .ctrl_d     (main_ctrl_d),
    .data_d     (main_data_d),
    .vld        (out_valid),
    .ctrl       (out_ctrl),
    .data       (out_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clr),
    .clear_data (clr_data),
    .ctrl_d     (in_ctrl),
    .data_d     (in_data),
    .vld        (skid_vld),
    .ctrl       (skid_ctrl),
    .data       (skid_data)
  );

endmodule

// File: tb/tb_id_exe_skid_stage.sv
// Directed bench for id_exe_skid_stage: reset, streaming, back-pressure,
// flush, randomised ready with a scoreboard, and reset while full.
module tb_id_exe_skid_stage;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 10;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  id_exe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_d;
  int                seq, got, cyc;
  logic              acc, emt;

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    push(10'h3FF, 96'hDEAD);
    repeat (3) step();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_occ",       128'(occupancy), 128'(0));
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("post_rst_valid", 128'(out_valid), 128'(0));
    chk("post_rst_occ",   128'(occupancy), 128'(0));

    // Streaming 1..8 back-to-back
    for (int i = 1; i <= 8; i++) begin
      push(CTRL_W'(i), DATA_W'(i));
      step();
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_data",  128'(out_data),  128'(i));
      chk("stream_ctrl",  128'(out_ctrl),  128'(i));
      chk("stream_occ",   128'(occupancy), 128'(1));
      chk("stream_rdy",   128'(in_ready),  128'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 128'(out_valid), 128'(0));
    chk("stream_drain_ctrl",  128'(out_ctrl),  128'(0));
    chk("stream_drain_occ",   128'(occupancy), 128'(0));

    // Back-pressure: A, B absorbed, C held upstream
    out_ready = 1'b0;
    push(10'h00A, 96'hA);
    step();
    chk("bp_a_occ",  128'(occupancy), 128'(1));
    chk("bp_a_rdy",  128'(in_ready),  128'(1));
    chk("bp_a_data", 128'(out_data),  128'hA);
    push(10'h00B, 96'hB);
    step();
    chk("bp_b_occ",  128'(occupancy), 128'(2));
    chk("bp_b_rdy",  128'(in_ready),  128'(0));
    chk("bp_b_data", 128'(out_data),  128'hA);
    push(10'h00C, 96'hC);
    step();
    chk("bp_c_occ",  128'(occupancy), 128'(2));
    chk("bp_c_rdy",  128'(in_ready),  128'(0));
    chk("bp_c_data", 128'(out_data),  128'hA);
    out_ready = 1'b1;
    step();
    chk("bp_emit_a_data", 128'(out_data),  128'hB);
    chk("bp_emit_a_occ",  128'(occupancy), 128'(1));
    chk("bp_emit_a_rdy",  128'(in_ready),  128'(1));
    step();
    chk("bp_emit_b_data", 128'(out_data),  128'hC);
    chk("bp_emit_b_ctrl", 128'(out_ctrl),  128'h00C);
    chk("bp_emit_b_occ",  128'(occupancy), 128'(1));
    in_valid = 1'b0;
    step();
    chk("bp_done_occ",   128'(occupancy), 128'(0));
    chk("bp_done_valid", 128'(out_valid), 128'(0));

    // Flush while FULL
    out_ready = 1'b0;
    push(10'h155, 96'h11);
    step();
    push(10'h155, 96'h22);
    step();
    chk("fl_full_occ", 128'(occupancy), 128'(2));
    flush = 1'b1;
    push(10'h155, 96'h33);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_ctrl",  128'(out_ctrl),  128'(0));
    chk("fl_occ",   128'(occupancy), 128'(0));
    chk("fl_rdy",   128'(in_ready),  128'(1));
    chk("fl_data",  128'(out_data),  128'h11);
    out_ready = 1'b1;
    step();
    chk("fl_after_valid", 128'(out_valid), 128'(0));

    // Flush while BUSY with a live handshake in the flush cycle
    push(10'h044, 96'h44);
    step();
    chk("flb_occ", 128'(occupancy), 128'(1));
    flush = 1'b1;
    push(10'h055, 96'h55);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flb_valid", 128'(out_valid), 128'(0));
    chk("flb_occ",   128'(occupancy), 128'(0));
    step();
    chk("flb_after_valid", 128'(out_valid), 128'(0));

    // Random out_ready over 1000 beats with a scoreboard
    seq = 1; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = DATA_W'(seq);
      in_ctrl   = CTRL_W'(seq);
      #1;
      acc = in_valid & in_ready;
      emt = out_valid & out_ready;
      chk("rnd_occ_model", 128'(occupancy), 128'(q.size()));
      if (emt) begin
        if (q.size() == 0) begin
          chk("rnd_emit_unexpected", 128'(out_valid), 128'(0));
        end else begin
          exp_d = q.pop_front();
          chk("rnd_data", 128'(out_data), 128'(exp_d));
          chk("rnd_ctrl", 128'(out_ctrl), 128'(exp_d[CTRL_W-1:0]));
          got++;
        end
      end
      if (acc) begin
        q.push_back(in_data);
        seq++;
      end
      step();
      cyc++;
    end
    chk("rnd_beats_done", 128'(got), 128'(1000));

    // Reset while FULL, flush asserted too
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    push(10'h066, 96'h66);
    step();
    push(10'h067, 96'h67);
    step();
    chk("rf_full_occ", 128'(occupancy), 128'(2));
    rst = 1'b0; flush = 1'b1;
    step();
    chk("rf_valid", 128'(out_valid), 128'(0));
    chk("rf_ctrl",  128'(out_ctrl),  128'(0));
    chk("rf_data",  128'(out_data),  128'(0));
    chk("rf_occ",   128'(occupancy), 128'(0));
    chk("rf_rdy",   128'(in_ready),  128'(1));
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    push(10'h077, 96'h77);
    step();
    in_valid = 1'b0;
    chk("rf_first_valid", 128'(out_valid), 128'(1));
    chk("rf_first_data",  128'(out_data),  128'h77);
    chk("rf_first_ctrl",  128'(out_ctrl),  128'h077);
    step();
    chk("rf_end_occ", 128'(occupancy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_exe_skid_stage.md
# id_exe_skid_stage

Parametrised, back-pressure-capable successor to the fixed ID/EXE pipeline register. It sits between any two pipeline stages (ID→EXE first, then EXE→MEM and MEM→WB). It carries a generic payload with valid/ready handshaking and a two-entry skid buffer, so `in_ready` comes straight from a flop. A synchronous flush kills in-flight instructions and forces control bits to zero (bubble).

## Interface
- `DATA_W`, default 96: payload width (PC, operand values, shift operand, imm24, dest…); kept on flush unless `CLEAR_DATA`=1.
- `CTRL_W`, default 10: control width (WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD, B, S, C flag…); forced to zero on reset, flush and bubble.
- `CLEAR_DATA`, default 0: 1 = payload also zeroed on flush.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held entries (branch taken).
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_ctrl`  in  CTRL_W  upstream control.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_ctrl`  out  CTRL_W  control; zero whenever `out_valid`=0.
- `out_data`  out  DATA_W  payload.
- `occupancy`  out  2  entries held (0, 1, 2).

## Operation
- Storage: main slot (drives outputs) and skid slot, each with valid, ctrl, data.
- Transfers: accept = `in_valid & in_ready`; emit = `out_valid & out_ready`.
- States: EMPTY (occ 0), BUSY (main only, occ 1), FULL (main + skid, occ 2).
- EMPTY: accept → BUSY, main ← input. No accept → stay.
- BUSY: accept & emit → BUSY, main ← input. Accept & no emit → FULL, skid ← input. Emit only → EMPTY. Neither → hold.
- FULL: `in_ready`=0, so no accept. Emit → BUSY, main ← skid, skid invalid. No emit → hold.
- `in_ready` = next-state ≠ FULL, registered.
- `out_valid` = main valid. `out_ctrl` = main valid ? main ctrl : 0. `out_data` = main data (held when not valid).
- Flush (`rst`=1, `flush`=1): both slots invalid, ctrl zeroed, data zeroed only if `CLEAR_DATA`. State → EMPTY, `in_ready` → 1. A beat handshaking in the flush cycle is dropped. An emit in the flush cycle still counts downstream, since outputs are registered values.
- Priority: reset > flush > normal.
- Order guaranteed: beats leave in acceptance order; none duplicated or lost except by flush/reset.

## Timing
- Reset (`rst`=0 at edge) gives: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=1, both slots invalid. Inputs during reset are ignored.
- Latency: beat accepted at edge N appears on outputs after edge N (1 cycle) when EMPTY, or when BUSY with a simultaneous emit.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- `out_ready` low for k cycles: at most 2 beats absorbed. `in_ready` falls the cycle after the second accept. It rises the cycle after the first emit from FULL.
- No combinational path from `out_ready` to `in_ready`. `out_*` are flop outputs.
- Flush when FULL: after the edge, occ=0 and `out_valid`=0.

## Structure
- Package `pipe_pkg`: state localparams `ST_EMPTY`=2'd0, `ST_BUSY`=2'd1, `ST_FULL`=2'd2. ID/EXE field widths and bit offsets for packing `ctrl`/`data` (EXE_CMD_W=4, IMM24_W=24, SHOP_W=12, REG_W=4).
- Natural sub-module: `pipe_slot`, one valid + ctrl + data register with load/clear/clear_data enables, instantiated twice.
- Wrapper packing ID/EXE fields is separate, not part of this block.

## Test plan
- Reset: hold `rst`=0 with `in_valid`=1, ctrl=0x3FF → `out_valid`=0, `out_ctrl`=0, `in_ready`=1, occ=0 after release.
- Stream: `out_ready`=1, push data 1..8 back-to-back → outputs 1..8 on consecutive cycles, one cycle after each accept, occ stays 1.
- Back-pressure: `out_ready`=0, push A, B, C → A, B accepted, `in_ready`=0 from the cycle after B. C is held upstream. Release `out_ready` → A, B, C emitted in order.
- Flush FULL: occ=2, ctrl=0x155, pulse `flush` with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, occ=0. Data retained (CLEAR_DATA=0) or 0 (CLEAR_DATA=1). Flush-cycle beat never appears.
- Simultaneous accept and emit in BUSY, random `out_ready` over 1000 beats → scoreboard order exact, no loss, occ never exceeds 2.
- Reset mid-FULL, `flush`=1 too → reset values as above. First beat after release appears with 1-cycle latency.
